// File: rtl/redmule_x_feeder.sv
// X operand feeder: takes stream words through a 2-entry FIFO, zero-masks the
// unused lanes of the leftover K-block, and writes rows into the X buffer tile by tile.
module redmule_x_feeder #(
  parameter int unsigned DW    = 288,
  parameter int unsigned BITW  = 16,  // FP16 element width
  parameter int unsigned Width = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [$clog2(Width):0]       cfg_width_i,
  input  logic [15:0]                  cfg_tiles_i,
  input  logic [$clog2(DW/BITW):0]     cfg_last_elems_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [DW-1:0]                s_data_i,
  output logic                         load_o,
  output logic [DW-1:0]                wdata_o,
  input  logic                         full_i,
  output logic                         rst_w_index_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned E  = DW / BITW;
  localparam int unsigned CW = $clog2(Width) + 1;
  localparam int unsigned LW = $clog2(E) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWaitFull, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   width_q, width_d;
  logic [CW-1:0]   row_cnt_q, row_cnt_d;
  logic [15:0]     tiles_q, tiles_d;
  logic [15:0]     tile_cnt_q, tile_cnt_d;
  logic [LW-1:0]   last_q, last_d;
  logic            done_zero_q, done_zero_d;  // done pulse for a zero-tile job
  logic [DW-1:0]   wdata_q;

  logic [DW-1:0]   mem_q [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            push;
  logic            is_last_tile;
  logic            mask_en;
  logic [DW-1:0]   head_masked;

  assign is_last_tile = (tile_cnt_q == (tiles_q - 16'd1));
  assign mask_en      = is_last_tile && (last_q != '0) && (last_q < LW'(E));

  // Handshake and control outputs; clear_i suppresses every event of its cycle.
  assign s_ready_o     = (cnt_q != 2'd2) && (state_q != StIdle) && !clear_i;
  assign push          = s_valid_i && s_ready_o;
  assign load_o        = (state_q == StLoad) && (cnt_q != 2'd0) && (row_cnt_q < width_q) &&
                         !clear_i;
  assign rst_w_index_o = (state_q == StWaitFull) && full_i && !clear_i;
  assign done_o        = ((state_q == StDone) || done_zero_q) && !clear_i;
  assign busy_o        = (state_q != StIdle);
  assign wdata_o       = load_o ? head_masked : wdata_q;

  // FIFO head with lanes at or above last_elems zeroed in the last tile.
  always_comb begin
    head_masked = mem_q[rd_ptr_q];
    for (int unsigned i = 0; i < E; i++) begin
      if (mask_en && (LW'(i) >= last_q)) begin
        head_masked[i*BITW +: BITW] = '0;
      end
    end
  end

  // Next-state logic for the FSM, counters and FIFO pointers.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    row_cnt_d   = row_cnt_q;
    tiles_d     = tiles_q;
    tile_cnt_d  = tile_cnt_q;
    last_d      = last_q;
    done_zero_d = 1'b0;
    wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d    = load_o ? ~rd_ptr_q : rd_ptr_q;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, load_o};

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          width_d    = cfg_width_i;
          tiles_d    = cfg_tiles_i;
          last_d     = cfg_last_elems_i;
          row_cnt_d  = '0;
          tile_cnt_d = '0;
          if (cfg_tiles_i == 16'd0) begin
            done_zero_d = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (load_o) begin
          row_cnt_d = row_cnt_q + CW'(1);
          if (row_cnt_d >= width_q) begin
            state_d = StWaitFull;
          end
        end
      end
      StWaitFull: begin
        if (full_i) begin
          row_cnt_d = '0;
          if (is_last_tile) begin
            state_d = StDone;
          end else begin
            tile_cnt_d = tile_cnt_q + 16'd1;
            state_d    = StLoad;
          end
        end
      end
      StDone: begin
        // Leftover words are dropped on the way back to idle.
        state_d  = StIdle;
        wr_ptr_d = 1'b0;
        rd_ptr_d = 1'b0;
        cnt_d    = 2'd0;
      end
      default: state_d = StIdle;
    endcase

    if (clear_i) begin
      state_d     = StIdle;
      width_d     = '0;
      row_cnt_d   = '0;
      tiles_d     = '0;
      tile_cnt_d  = '0;
      last_d      = '0;
      done_zero_d = 1'b0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      cnt_d       = 2'd0;
    end
  end

  // State, counter and FIFO registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      width_q     <= '0;
      row_cnt_q   <= '0;
      tiles_q     <= '0;
      tile_cnt_q  <= '0;
      last_q      <= '0;
      done_zero_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      wdata_q     <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      row_cnt_q   <= row_cnt_d;
      tiles_q     <= tiles_d;
      tile_cnt_q  <= tile_cnt_d;
      last_q      <= last_d;
      done_zero_q <= done_zero_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      wdata_q     <= clear_i ? '0 : wdata_o;
      if (push) begin
        mem_q[wr_ptr_q] <= s_data_i;
      end
    end
  end

endmodule

// File: doc/redmule_x_feeder.md
Name: redmule_x_feeder

Overview:
- Upstream neighbour of the X buffer. Accepts X operand words from the streamer over a valid/ready handshake and decouples them through a 2-entry FIFO.
- Zero-masks the unused lanes of the leftover (last) K-block.
- Drives the X buffer's load/wdata write port, counts the rows of each tile, and ends each tile by pulsing rst_w_index_o once the buffer reports full.

Parameters:
DW, 288, stream and buffer word width in bits
FpFormat, fpnew_pkg::FP16, element format; BITW = fpnew_pkg::fp_width(FpFormat)
Width, ARRAY_WIDTH, maximum rows per tile; E = DW/BITW elements per word (localparam)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear; same effect as reset
start_i  in  1  latch config and begin a job; ignored unless IDLE
cfg_width_i  in  $clog2(Width)+1  rows per tile, legal range 1..Width
cfg_tiles_i  in  16  number of tiles in the job; 0 means no tiles
cfg_last_elems_i  in  $clog2(E)+1  valid elements per word in the last tile; 0 or E means no masking
s_valid_i  in  1  stream word valid
s_ready_o  out  1  stream word ready
s_data_i  in  DW  stream word
load_o  out  1  write pulse to X buffer (ctrl.load)
wdata_o  out  DW  word to X buffer (x_buffer_i)
full_i  in  1  X buffer full flag
rst_w_index_o  out  1  one-cycle acknowledge of full (ctrl.rst_w_index)
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset/clear: state IDLE; FIFO empty; all counters 0; every output 0 (wdata_o = '0).
- Config is latched on start_i in IDLE. A start_i arriving outside IDLE is dropped.
- FIFO:
  - 2 entries with registered pointers and count.
  - s_ready_o = (count < 2) && state != IDLE.
  - Push when s_valid_i && s_ready_o; pop when load_o.
  - Simultaneous push and pop when count = 2 cannot occur, because ready is computed from the registered count (no bypass).
  - Latency from accepted word to earliest load_o: 1 cycle.
- FSM:
  - IDLE -> LOAD on start_i with cfg_tiles_i != 0. With cfg_tiles_i == 0: done_o pulses the next cycle and the state stays IDLE.
  - LOAD:
    - load_o = FIFO non-empty && row_cnt < width.
    - Each load increments row_cnt.
    - When row_cnt reaches width, go to WAIT_FULL.
  - WAIT_FULL:
    - load_o = 0.
    - When full_i = 1, assert rst_w_index_o for exactly that one cycle and clear row_cnt.
    - If tile_cnt == tiles-1, go to DONE; otherwise increment tile_cnt and go to LOAD.
    - The stream may keep filling the FIFO during WAIT_FULL.
  - DONE: done_o = 1 for one cycle, then IDLE. Any words left in the FIFO are discarded on entry to IDLE.
- busy_o = (state != IDLE).
- Masking:
  - Applies only when tile_cnt == tiles-1 and 0 < last_elems < E.
  - Lane i (bits [i*BITW +: BITW]) of wdata_o is forced to 0 for every i >= last_elems.
  - In all other cases the word passes unmodified.
- wdata_o:
  - Driven from the FIFO head.
  - Holds its last value when load_o = 0; '0 after reset/clear.
- Widths: row_cnt is $clog2(Width)+1 bits; tile_cnt is 16 bits. Neither counter wraps within a legal config.
- full_i asserted in LOAD is ignored; only WAIT_FULL samples it.
- clear_i mid-job returns the block to IDLE in the next cycle with no done_o pulse. clear_i has priority over every event in the same cycle.

Test Plan:
- Single tile: width=4, tiles=1, words A..D streamed back-to-back, full_i raised 2 cycles after the 4th load -> 4 load_o pulses carrying A..D; rst_w_index_o for 1 cycle; done_o 1 cycle later; busy_o low afterwards.
- Backpressure: s_valid_i continuously high, full_i held 0 for 10 cycles after the tile is loaded -> s_ready_o drops after 2 extra words are accepted, no loads occur in WAIT_FULL, and the next tile's first load carries the first buffered word.
- Masking: E=18, last_elems=5, tiles=2 -> tile-0 words unmodified; tile-1 words have lanes 5..17 = 0 and lanes 0..4 intact.
- Stream bubbles: width=3 with s_valid_i toggling every cycle -> exactly 3 loads with data in order; no load without FIFO data.
- Edge configs:
  - tiles=0 -> done_o the cycle after start and no s_ready_o.
  - width=1, tiles=3 -> 3 loads and 3 rst_w_index_o pulses.
  - start_i while busy -> ignored.
- Clear mid-job: assert clear_i after 2 loads of a width-4 tile -> state IDLE, all outputs 0, no done_o; a new start_i then runs normally.
